instr_rom_fetch: RTL and testbench
==================================

INSTR_ROM_FETCH -- requirements
Module: instr_rom_fetch

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the instruction word width.
REQ-002 Parameter ADDR_W, default 8, SHALL set the program-counter and address width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of stored words; DEPTH SHALL be no greater than 2^ADDR_W.
REQ-004 Parameter NOP_WORD, default all-zero, SHALL set the word returned for unwritten or out-of-range addresses.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-007 Port ld_en, input, 1 bit: program-load write strobe.
REQ-008 Port ld_addr, input, ADDR_W bits: program-load word address.
REQ-009 Port ld_data, input, DATA_W bits: program-load word.
REQ-010 Port rd_req, input, 1 bit: fetch request.
REQ-011 Port pc, input, ADDR_W bits: fetch address.
REQ-012 Port rd_stall, input, 1 bit: consumer is not taking the presented instruction.
REQ-013 Port rd_ready, output, 1 bit: a fetch request is accepted this cycle.
REQ-014 Port instr, output, DATA_W bits: fetched instruction.
REQ-015 Port instr_valid, output, 1 bit: instr is valid.
REQ-016 Port loaded_cnt, output, ADDR_W+1 bits: number of distinct addresses written since reset.

Function
REQ-017 Storage SHALL be DEPTH words of DATA_W bits, plus one written-flag per word.
REQ-018 The FSM SHALL have three states:
- IDLE: no instruction presented.
- FETCH: instruction presented, not stalled.
- HOLD: instruction presented and stalled.
REQ-019 rd_ready SHALL be 1 in IDLE and FETCH, and 0 in HOLD.
REQ-020 rd_req with rd_ready=1 SHALL capture pc. On the next edge the block SHALL set instr to the stored word, set instr_valid=1 and enter FETCH; read latency is exactly 1 cycle.
REQ-021 The read SHALL return NOP_WORD when the word's written-flag is 0 or pc >= DEPTH.
REQ-022 In FETCH with rd_stall=1 and no accepted request, the block SHALL enter HOLD.
REQ-023 In HOLD, instr and instr_valid SHALL hold unchanged and rd_req SHALL be ignored.
REQ-024 In HOLD with rd_stall=0, the block SHALL return to FETCH with rd_ready=1 in the following cycle.
REQ-025 In FETCH with rd_req=0 and rd_stall=0, the block SHALL set instr_valid=0 and go to IDLE.
REQ-026 When rd_stall=1 and rd_req=1 are both asserted in FETCH, the request SHALL take priority: it is accepted, the new word is presented, and the state stays FETCH.
REQ-027 ld_en=1 SHALL write ld_data at ld_addr and set its written-flag in any FSM state.
REQ-028 A write with ld_addr >= DEPTH SHALL be ignored.
REQ-029 loaded_cnt SHALL increment by 1 only when a write sets a previously clear written-flag, saturating at DEPTH.
REQ-030 On a same-cycle load and fetch of the same address, the fetch SHALL return the pre-write contents (read-before-write). The write SHALL be visible to the next fetch.
REQ-031 Consecutive accepted requests SHALL sustain one instruction per cycle, with no bubble.

Reset
REQ-032 rst=1 on an edge SHALL force: state IDLE, instr=NOP_WORD, instr_valid=0, loaded_cnt=0, all written-flags cleared. Word contents need not be cleared.
REQ-033 rst SHALL override ld_en and rd_req in the same cycle, including mid-HOLD. rd_ready SHALL be 1 in the cycle after reset is released.

Verification
REQ-034 Reset, then fetch pc=0x05 -> instr=0x0000, instr_valid=1 one cycle later; loaded_cnt=0.
REQ-035 Load 0xA208@0x00, 0xAA00@0x01, 0x9AFD@0x02; fetch pc 0,1,2 back-to-back -> instr 0xA208, 0xAA00, 0x9AFD on three consecutive cycles; loaded_cnt=3.
REQ-036 Fetch 0x01, assert rd_stall for 3 cycles while rd_req=0 -> HOLD, instr=0xAA00 held, rd_ready=0. Release the stall -> rd_ready=1 the next cycle.
REQ-037 Same-cycle load 0x1234@0x00 and fetch pc=0x00 -> instr=0xA208; the next fetch of 0x00 -> 0x1234; loaded_cnt is unchanged (rewrite).
REQ-038 With DEPTH=200: load @0xF0 -> ignored; fetch 0xF0 -> NOP_WORD; loaded_cnt unchanged.
REQ-039 Assert rst during HOLD together with ld_en -> next cycle instr_valid=0, loaded_cnt=0; a fetch of 0x00 then returns NOP_WORD.

Source files
------------

// File: rtl/instr_rom_fetch.sv
// Loadable instruction store with a one-cycle fetch port and a stall-aware
// present/hold handshake toward the instruction consumer.
module instr_rom_fetch #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rd_stall,
  output logic              rd_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W:0]   loaded_cnt
);

  localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    written;

  logic [IDX_W-1:0]    ld_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic                ld_ok;
  logic                ld_new;
  logic                rd_ok;
  logic [DATA_W-1:0]   rd_word;
  logic                accept;

  always_comb begin
    ld_idx   = ld_addr[IDX_W-1:0];
    rd_idx   = pc[IDX_W-1:0];
    ld_ok    = ld_en && ({1'b0, ld_addr} < DEPTH_C);
    ld_new   = ld_ok && !written[ld_idx];
    rd_ok    = {1'b0, pc} < DEPTH_C;
    // Reads see the pre-edge array and flags, giving read-before-write.
    rd_word  = (rd_ok && written[rd_idx]) ? mem[rd_idx] : NOP_WORD;
    rd_ready = (state != StHold);
    accept   = rd_req && rd_ready;
  end

  // Word array carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (ld_ok && !rst) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      loaded_cnt  <= '0;
      written     <= '0;
    end else begin
      if (ld_ok) begin
        written[ld_idx] <= 1'b1;
      end
      if (ld_new && (loaded_cnt < DEPTH_C)) begin
        loaded_cnt <= loaded_cnt + CNT_ONE;
      end

      case (state)
        StIdle, StFetch: begin
          // A new request wins over a stall of the word being presented.
          if (accept) begin
            instr       <= rd_word;
            instr_valid <= 1'b1;
            state       <= StFetch;
          end else if ((state == StFetch) && rd_stall) begin
            state <= StHold;
          end else begin
            instr_valid <= 1'b0;
            state       <= StIdle;
          end
        end
        StHold: begin
          if (!rd_stall) begin
            state <= StFetch;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Directed bench for instr_rom_fetch: vector table for the main scenarios
// plus hand-written fill/saturate and back-to-back streaming sequences.
module tb_instr_rom_fetch;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          rd_req;
  logic [AW-1:0] pc;
  logic          rd_stall;
  logic          rd_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [AW:0]   loaded_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_rom_fetch #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rd_req      (rd_req),
    .pc          (pc),
    .rd_stall    (rd_stall),
    .rd_ready    (rd_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .loaded_cnt  (loaded_cnt)
  );

  typedef struct {
    logic          rst;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          rd_req;
    logic [AW-1:0] pc;
    logic          rd_stall;
    logic          ev;   // expected instr_valid
    logic          ci;   // compare instr on this row
    logic [DW-1:0] ei;
    logic          er;   // expected rd_ready
    logic [AW:0]   ec;   // expected loaded_cnt
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic le, input logic [AW-1:0] la,
                     input logic [DW-1:0] ld, input logic rq, input logic [AW-1:0] p,
                     input logic st, input logic ev, input logic ci,
                     input logic [DW-1:0] ei, input logic er, input logic [AW:0] ec);
    vec_t v;
    v.rst = r; v.ld_en = le; v.ld_addr = la; v.ld_data = ld;
    v.rd_req = rq; v.pc = p; v.rd_stall = st;
    v.ev = ev; v.ci = ci; v.ei = ei; v.er = er; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    rd_req = 1'b0; pc = '0; rd_stall = 1'b0;
  endtask

  function automatic logic [DW-1:0] fill_word(input int i);
    return 16'h3C00 ^ DW'(i * 37);
  endfunction

  initial begin
    //  rst le addr   data      rq pc     st | v  ci instr     rdy cnt
    add(1, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 1, 16'h0000, 1, 0);  // 0 reset
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 1, 16'h0000, 1, 0);  // 1 idle
    add(0, 0, 8'h00, 16'h0000, 1, 8'h05, 0,   1, 1, 16'h0000, 1, 0);  // 2 fetch unwritten
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 0);  // 3 back to idle
    add(0, 1, 8'h00, 16'hA208, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 1);  // 4 loads
    add(0, 1, 8'h01, 16'hAA00, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 2);
    add(0, 1, 8'h02, 16'h9AFD, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);
    add(0, 0, 8'h00, 16'h0000, 1, 8'h00, 0,   1, 1, 16'hA208, 1, 3);  // 7 back-to-back
    add(0, 0, 8'h00, 16'h0000, 1, 8'h01, 0,   1, 1, 16'hAA00, 1, 3);
    add(0, 0, 8'h00, 16'h0000, 1, 8'h02, 0,   1, 1, 16'h9AFD, 1, 3);
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);  // 10
    add(0, 0, 8'h00, 16'h0000, 1, 8'h01, 0,   1, 1, 16'hAA00, 1, 3);  // 11 stall seq
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 1,   1, 1, 16'hAA00, 0, 3);  // 12 -> hold
    add(0, 0, 8'h00, 16'h0000, 1, 8'h02, 1,   1, 1, 16'hAA00, 0, 3);  // 13 req ignored
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 1,   1, 1, 16'hAA00, 0, 3);
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   1, 1, 16'hAA00, 1, 3);  // 15 release
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);
    add(0, 0, 8'h00, 16'h0000, 1, 8'h00, 0,   1, 1, 16'hA208, 1, 3);  // 17
    add(0, 0, 8'h00, 16'h0000, 1, 8'h02, 1,   1, 1, 16'h9AFD, 1, 3);  // 18 req beats stall
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);
    add(0, 1, 8'h00, 16'h1234, 1, 8'h00, 0,   1, 1, 16'hA208, 1, 3);  // 20 read-before-write
    add(0, 0, 8'h00, 16'h0000, 1, 8'h00, 0,   1, 1, 16'h1234, 1, 3);
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);
    add(0, 1, 8'hF0, 16'hBEEF, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 3);  // 23 out of range
    add(0, 0, 8'h00, 16'h0000, 1, 8'hF0, 0,   1, 1, 16'h0000, 1, 3);
    add(0, 1, 8'hC7, 16'h5A5A, 1, 8'hC7, 0,   1, 1, 16'h0000, 1, 4);  // 25 last word
    add(0, 0, 8'h00, 16'h0000, 1, 8'hC7, 0,   1, 1, 16'h5A5A, 1, 4);
    add(0, 1, 8'hC8, 16'h1111, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 4);  // 27 first beyond
    add(0, 0, 8'h00, 16'h0000, 1, 8'hC8, 0,   1, 1, 16'h0000, 1, 4);
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 1,   1, 1, 16'h0000, 0, 4);  // 29 hold
    add(1, 1, 8'h03, 16'h7777, 1, 8'h03, 1,   0, 1, 16'h0000, 1, 0);  // 30 reset in hold
    add(0, 0, 8'h00, 16'h0000, 1, 8'h00, 0,   1, 1, 16'h0000, 1, 0);  // 31 flags cleared
    add(0, 0, 8'h00, 16'h0000, 1, 8'h03, 0,   1, 1, 16'h0000, 1, 0);
    add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 0);
    add(0, 1, 8'h03, 16'h7777, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 1);  // 34
    add(0, 0, 8'h00, 16'h0000, 1, 8'h03, 0,   1, 1, 16'h7777, 1, 1);
    add(0, 1, 8'h03, 16'h8888, 0, 8'h00, 0,   0, 0, 16'h0000, 1, 1);  // 36 rewrite

    idle_inputs();
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; ld_en = vecs[i].ld_en; ld_addr = vecs[i].ld_addr;
      ld_data = vecs[i].ld_data; rd_req = vecs[i].rd_req; pc = vecs[i].pc;
      rd_stall = vecs[i].rd_stall;
      step();
      check("instr_valid", i, 32'(instr_valid), 32'(vecs[i].ev));
      check("rd_ready", i, 32'(rd_ready), 32'(vecs[i].er));
      check("loaded_cnt", i, 32'(loaded_cnt), 32'(vecs[i].ec));
      if (vecs[i].ci) check("instr", i, 32'(instr), 32'(vecs[i].ei));
    end

    // Fill every word, then confirm saturation and that a rewrite is not counted.
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DP; i++) begin
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = fill_word(i);
      step();
    end
    check("fill_cnt", 100, 32'(loaded_cnt), 32'(DP));
    ld_addr = 8'h05; ld_data = 16'hFFFF;
    step();
    check("sat_cnt", 101, 32'(loaded_cnt), 32'(DP));
    ld_en = 1'b0;

    // Stream all addresses on consecutive cycles; each must land one cycle later.
    for (int i = 0; i < DP; i++) begin
      rd_req = 1'b1; pc = AW'(i);
      step();
      check("stream_valid", 200 + i, 32'(instr_valid), 32'd1);
      check("stream_instr", 200 + i, 32'(instr),
            (i == 5) ? 32'h0000FFFF : 32'(fill_word(i)));
    end
    rd_req = 1'b0;
    step();
    check("stream_end", 400, 32'(instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
